// File: rtl/pulse_gen_if.sv
// Configuration, trigger and pulse-status bundle between the UART front end and pulse_gen.
interface pulse_gen_if;
  logic        trigger_i;
  logic        en_i;
  logic [15:0] delay_i;
  logic [7:0]  width_i;
  logic [7:0]  num_pulses_i;
  logic [15:0] spacing_i;
  logic        pulse_o;
  logic        armed_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output trigger_i, en_i, delay_i, width_i, num_pulses_i, spacing_i,
    input  pulse_o, armed_o, busy_o, done_o
  );

  modport slave (
    input  trigger_i, en_i, delay_i, width_i, num_pulses_i, spacing_i,
    output pulse_o, armed_o, busy_o, done_o
  );
endinterface

// File: rtl/pulse_gen.sv
// Glitch pulse sequencer: on a synchronised trigger edge, emits a burst of
// timed pulses using configuration latched at trigger time.
module pulse_gen #(
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       rst,
  pulse_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    SPACE = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   trig_edge_s;
  state_t                 state_r, state_s;
  logic [15:0]            timer_r, timer_s;
  logic [7:0]             count_r, count_s;
  logic [7:0]             width_r, width_s;
  logic [15:0]            spacing_r, spacing_s;
  logic [7:0]             width_cl_s;
  logic [15:0]            spacing_cl_s;
  logic                   done_s;
  logic                   pulse_r, armed_r, busy_r, done_r;

  assign trig_edge_s  = sync_r[SYNC_STAGES-1] & ~hist_r;
  assign width_cl_s   = (bus.width_i == 8'd0) ? 8'd1 : bus.width_i;
  assign spacing_cl_s = (bus.spacing_i == 16'd0) ? 16'd1 : bus.spacing_i;

  // Trigger synchroniser chain plus history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.trigger_i};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Next-state logic; a single timer is reloaded with delay, width or spacing.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    count_s   = count_r;
    width_s   = width_r;
    spacing_s = spacing_r;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.en_i) state_s = ARMED;
        else          state_s = IDLE;
      end
      ARMED: begin
        if (!bus.en_i) begin
          state_s = IDLE;
        end else if (trig_edge_s && (bus.num_pulses_i != 8'd0)) begin
          width_s   = width_cl_s;
          spacing_s = spacing_cl_s;
          count_s   = bus.num_pulses_i;
          if (bus.delay_i != 16'd0) begin
            state_s = DELAY;
            timer_s = bus.delay_i;
          end else begin
            state_s = PULSE;
            timer_s = {8'd0, width_cl_s};
          end
        end else begin
          state_s = ARMED;
        end
      end
      DELAY: begin
        if (!bus.en_i) begin
          state_s = IDLE;
        end else if (timer_r == 16'd1) begin
          state_s = PULSE;
          timer_s = {8'd0, width_r};
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      PULSE: begin
        if (!bus.en_i) begin
          state_s = IDLE;
        end else if (timer_r == 16'd1) begin
          count_s = count_r - 8'd1;
          if (count_r == 8'd1) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = SPACE;
            timer_s = spacing_r;
          end
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      SPACE: begin
        if (!bus.en_i) begin
          state_s = IDLE;
        end else if (timer_r == 16'd1) begin
          state_s = PULSE;
          timer_s = {8'd0, width_r};
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched burst configuration and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      timer_r   <= 16'd0;
      count_r   <= 8'd0;
      width_r   <= 8'd0;
      spacing_r <= 16'd0;
      pulse_r   <= 1'b0;
      armed_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      count_r   <= count_s;
      width_r   <= width_s;
      spacing_r <= spacing_s;
      pulse_r   <= (state_s == PULSE);
      armed_r   <= (state_s == ARMED);
      busy_r    <= (state_s == DELAY) || (state_s == PULSE) || (state_s == SPACE);
      done_r    <= done_s;
    end
  end

  assign bus.pulse_o = pulse_r;
  assign bus.armed_o = armed_r;
  assign bus.busy_o  = busy_r;
  assign bus.done_o  = done_r;

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: stimulus pushes expected pulse/done events,
// a negedge monitor measures observed pulses and pops/compares them.
module tb_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    bit is_done;
    int at_cyc;
    int width;
  } ev_t;

  ev_t exp_q[$];

  pulse_gen_if bus ();

  pulse_gen #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic void push_pulse(input int at_c, input int w);
    ev_t e;
    e.is_done = 1'b0;
    e.at_cyc  = at_c;
    e.width   = w;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(input int at_c);
    ev_t e;
    e.is_done = 1'b1;
    e.at_cyc  = at_c;
    e.width   = 0;
    exp_q.push_back(e);
  endfunction

  // Monitor: measure each pulse at its fall, catch done strobes, pop and compare.
  bit prev_p = 1'b0;
  int rise_c = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_p = 1'b0;
    end else begin
      if (bus.pulse_o && !prev_p) rise_c = cyc;
      if (!bus.pulse_o && prev_p) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", rise_c, -1);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", 0, int'(e.is_done));
          chk("pulse_rise", rise_c, e.at_cyc);
          chk("pulse_width", cyc - rise_c, e.width);
        end
      end
      if (bus.done_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", cyc, -1);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("done_kind", 1, int'(e.is_done));
          chk("done_cycle", cyc, e.at_cyc);
          chk("busy_at_done", int'(bus.busy_o), 0);
        end
      end
      if (bus.armed_o && bus.busy_o) chk("armed_busy_excl", 1, 0);
      prev_p = bus.pulse_o;
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Fresh rising trigger edge; t0 is the cycle count right after edge 0.
  task automatic fire(output int t0);
    bus.trigger_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.trigger_i = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic config_set(input int d, input int w, input int n, input int s);
    bus.delay_i      = 16'(d);
    bus.width_i      = 8'(w);
    bus.num_pulses_i = 8'(n);
    bus.spacing_i    = 16'(s);
  endtask

  // Hand-computed first-rise offset, clamped width and rise-to-rise period per vector.
  task automatic burst(input int first, input int wc, input int period, input int n,
                       output int t0);
    fire(t0);
    for (int k = 0; k < n; k++) push_pulse(t0 + first + k * period, wc);
    push_done(t0 + first + (n - 1) * period + wc);
  endtask

  int t0;

  initial begin
    bus.trigger_i = 1'b0;
    bus.en_i      = 1'b0;
    config_set(0, 0, 0, 0);

    #12;
    chk("rst_pulse", int'(bus.pulse_o), 0);
    chk("rst_armed", int'(bus.armed_o), 0);
    chk("rst_busy",  int'(bus.busy_o),  0);
    chk("rst_done",  int'(bus.done_o),  0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", int'(bus.armed_o), 0);
    bus.en_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("armed", int'(bus.armed_o), 1);

    // Basic burst: delay 10, width 4, 3 pulses, spacing 6.
    config_set(10, 4, 3, 6);
    burst(12, 4, 10, 3, t0);
    wait_cyc(t0 + 40);
    chk("basic_drain", exp_q.size(), 0);

    // Zero values clamp to 1-cycle width/spacing; first rise at edge 2.
    config_set(0, 0, 2, 0);
    burst(2, 1, 2, 2, t0);
    wait_cyc(t0 + 10);
    chk("zero_drain", exp_q.size(), 0);

    // num=0: no activity, stays armed.
    config_set(3, 4, 0, 2);
    fire(t0);
    wait_cyc(t0 + 15);
    chk("num0_armed", int'(bus.armed_o), 1);
    chk("num0_busy", int'(bus.busy_o), 0);

    // Abort during second pulse: second pulse cut to 3 cycles, no done.
    config_set(3, 8, 3, 2);
    fire(t0);
    push_pulse(t0 + 5, 8);
    push_pulse(t0 + 15, 3);
    wait_cyc(t0 + 17);
    bus.en_i = 1'b0;
    @(negedge clk);
    chk("abort_pulse", int'(bus.pulse_o), 0);
    chk("abort_busy", int'(bus.busy_o), 0);
    chk("abort_armed", int'(bus.armed_o), 0);
    // Re-arm with trigger still high: no new burst.
    bus.en_i = 1'b1;
    wait_cyc(t0 + 45);
    chk("abort_drain", exp_q.size(), 0);
    chk("rearm_armed", int'(bus.armed_o), 1);

    // Config isolation: width change mid-burst keeps old width; held trigger no retrigger.
    config_set(2, 3, 2, 4);
    burst(4, 3, 7, 2, t0);
    wait_cyc(t0 + 6);
    bus.width_i = 8'd6;
    wait_cyc(t0 + 40);
    chk("iso_drain", exp_q.size(), 0);
    chk("iso_armed", int'(bus.armed_o), 1);
    burst(4, 6, 10, 2, t0);
    wait_cyc(t0 + 25);
    chk("newwidth_drain", exp_q.size(), 0);

    // Asynchronous reset mid-burst while in DELAY.
    config_set(100, 5, 3, 2);
    fire(t0);
    wait_cyc(t0 + 20);
    chk("pre_rst_busy", int'(bus.busy_o), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pulse", int'(bus.pulse_o), 0);
    chk("arst_busy",  int'(bus.busy_o),  0);
    chk("arst_armed", int'(bus.armed_o), 0);
    chk("arst_done",  int'(bus.done_o),  0);
    bus.trigger_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_idle", int'(bus.armed_o), 0);
    repeat (3) @(negedge clk);
    chk("post_rst_armed", int'(bus.armed_o), 1);
    chk("post_rst_busy", int'(bus.busy_o), 0);
    chk("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
